row_fetch_buffer: RTL and testbench



---
 rtl/tetris_pkg.sv | 9 +
 rtl/row_fetch_buffer_if.sv | 13 +
 rtl/row_bank.sv | 32 +++
 rtl/row_fetch_buffer.sv | 111 +++++++++++
 tb/tb_row_fetch_buffer.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tetris_pkg.sv
// tetris_pkg: shared playfield geometry defaults, cell type and row-loader states
package tetris_pkg;
  localparam int DEF_COLS = 10;
  localparam int DEF_ROWS = 20;
  localparam int DEF_ROW_STRIDE = 16;
  localparam int DEF_CELL_W = 16;
  typedef logic [DEF_CELL_W-1:0] cell_t;
  typedef enum logic [1:0] {IDLE, LOAD, FETCH, DONE} rowfetch_state_e;
endpackage

// File: rtl/row_fetch_buffer_if.sv
// row_fetch_buffer_if: SDRAM read-FIFO side of the row loader
interface row_fetch_buffer_if #(
  parameter int ADDR_W = 25,
  parameter int CELL_W = 16
);
  logic rd_load;
  logic [ADDR_W-1:0] rd_addr;
  logic rd;
  logic [CELL_W-1:0] rd_data;
  logic [15:0] rd_use;
  modport master(output rd_load, rd_addr, rd, input rd_data, rd_use);
  modport slave(input rd_load, rd_addr, rd, output rd_data, rd_use);
endinterface

// File: rtl/row_bank.sv
// row_bank: front/back row register banks; writes go to the back bank, reads see the front
module row_bank #(
  parameter int COLS = 10,
  parameter int CELL_W = 16,
  parameter int IW = $clog2(COLS + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic we,
  input  logic zero,
  input  logic swap,
  input  logic [IW-1:0] widx,
  input  logic [CELL_W-1:0] wdata,
  output logic [CELL_W-1:0] row_data [COLS]
);
  logic [CELL_W-1:0] bank [2][COLS];
  logic sel;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sel <= 1'b0;
      for (int i = 0; i < COLS; i++) begin
        bank[0][i] <= '0;
        bank[1][i] <= '0;
      end
    end else begin
      if (swap) sel <= ~sel;
      for (int i = 0; i < COLS; i++)
        if (zero || (we && int'(widx) == i)) bank[~sel][i] <= zero ? '0 : wdata;
    end
  always_comb
    for (int i = 0; i < COLS; i++) row_data[i] = bank[sel][i];
endmodule

// File: rtl/row_fetch_buffer.sv
// row_fetch_buffer: double-buffered playfield row loader from the SDRAM read FIFO
module row_fetch_buffer
  import tetris_pkg::*;
#(
  parameter int COLS = DEF_COLS,
  parameter int CELL_W = DEF_CELL_W,
  parameter int ROWS = DEF_ROWS,
  parameter int ROW_STRIDE = DEF_ROW_STRIDE,
  parameter int ADDR_W = 25,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int TIMEOUT = 255
) (
  input  logic Clk,
  input  logic Reset,
  input  logic hs,
  input  logic ld_row,
  input  logic [7:0] row_num,
  output logic busy,
  row_fetch_buffer_if.master sd,
  output logic [CELL_W-1:0] row_data [COLS],
  output logic [7:0] row_num_out,
  output logic row_ready,
  output logic fetch_err
);
  localparam int CW = $clog2(COLS + 1);
  localparam int IW = $clog2(TIMEOUT + 1);
  rowfetch_state_e state, state_n;
  logic [CW-1:0] issued, captured;
  logic [IW-1:0] idle;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0] row_q;
  logic rd, rd_prev, done_arm, take, zero, timeout, swap, in_range;
  assign in_range = int'(row_num) < ROWS;
  assign busy = state != IDLE;
  assign sd.rd_load = state == LOAD;
  assign sd.rd_addr = rd_addr;
  assign sd.rd = rd;
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) state <= IDLE;
    else state <= state_n;
  // the back bank is cleared before every fill so a timeout leaves the unfetched cells at zero
  always_comb begin
    state_n = state;
    rd = 1'b0;
    take = 1'b0;
    zero = 1'b0;
    timeout = 1'b0;
    swap = 1'b0;
    case (state)
      IDLE: begin
        take = ld_row && !row_ready;
        zero = take && !in_range;
        state_n = !take ? IDLE : in_range ? LOAD : DONE;
      end
      LOAD: begin
        zero = 1'b1;
        state_n = FETCH;
      end
      FETCH: begin
        rd = int'(issued) < COLS && (sd.rd_use > 16'd1 || (sd.rd_use == 16'd1 && !rd_prev));
        timeout = !rd_prev && int'(idle) == TIMEOUT - 1;
        state_n = (rd_prev && int'(captured) == COLS - 1) || timeout ? DONE : FETCH;
      end
      default: begin
        swap = done_arm && hs;
        state_n = swap ? IDLE : DONE;
      end
    endcase
  end
  // done_arm keeps an hs in the first DONE cycle from swapping
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      issued <= '0;
      captured <= '0;
      idle <= '0;
      rd_addr <= '0;
      row_q <= '0;
      rd_prev <= 1'b0;
      done_arm <= 1'b0;
      row_ready <= 1'b0;
      fetch_err <= 1'b0;
      row_num_out <= '0;
    end else begin
      rd_prev <= rd;
      done_arm <= state == DONE;
      row_ready <= swap;
      if (timeout) fetch_err <= 1'b1;
      if (swap) row_num_out <= row_q;
      if (take) row_q <= row_num;
      if (take && in_range) rd_addr <= BASE_ADDR + ADDR_W'(row_num) * ADDR_W'(ROW_STRIDE);
      if (state == LOAD) begin
        issued <= '0;
        captured <= '0;
        idle <= '0;
      end else if (state == FETCH) begin
        if (rd) issued <= issued + 1'b1;
        if (rd_prev) captured <= captured + 1'b1;
        idle <= rd_prev ? '0 : idle + 1'b1;
      end
    end
  row_bank #(.COLS(COLS), .CELL_W(CELL_W), .IW(CW)) u_bank (
    .clk(Clk),
    .rst(Reset),
    .we(state == FETCH && rd_prev),
    .zero(zero),
    .swap(swap),
    .widx(captured),
    .wdata(sd.rd_data),
    .row_data(row_data)
  );
endmodule

// File: tb/tb_row_fetch_buffer.sv
// tb_row_fetch_buffer: directed stimulus with a cycle-level reference model of the row loader
module tb_row_fetch_buffer;
  import tetris_pkg::*;
  localparam int COLS = 10, ROWS = 20, STRIDE = 16, TMO = 255;
  logic Clk = 1'b0, Reset = 1'b1, hs = 1'b0, ld_row = 1'b0;
  logic [7:0] row_num = '0;
  logic busy, row_ready, fetch_err;
  logic [7:0] row_num_out;
  cell_t row_data [COLS];
  int total = 0, bad = 0;
  row_fetch_buffer_if #(.ADDR_W(25), .CELL_W(16)) sd ();
  row_fetch_buffer #(
    .COLS(COLS), .CELL_W(16), .ROWS(ROWS), .ROW_STRIDE(STRIDE),
    .ADDR_W(25), .BASE_ADDR(25'h0), .TIMEOUT(TMO)
  ) dut (
    .Clk(Clk), .Reset(Reset), .hs(hs), .ld_row(ld_row), .row_num(row_num),
    .busy(busy), .sd(sd), .row_data(row_data), .row_num_out(row_num_out),
    .row_ready(row_ready), .fetch_err(fetch_err)
  );
  always #5 Clk = ~Clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask
  // SDRAM read FIFO: rd_load flushes it, then the burst words arrive at the chosen rate
  cell_t src[$];
  cell_t fifo[$];
  int rate = 0;
  initial begin : fifo_model
    logic r, l;
    int timer;
    timer = 0;
    sd.rd_data = '0;
    sd.rd_use = '0;
    forever begin
      @(negedge Clk);
      r = sd.rd;
      l = sd.rd_load;
      @(posedge Clk);
      #1;
      if (l) begin
        fifo.delete();
        timer = 0;
        if (rate == 0) while (src.size() > 0) fifo.push_back(src.pop_front());
      end else begin
        if (r && fifo.size() > 0) sd.rd_data = fifo.pop_front();
        if (rate > 0 && src.size() > 0) begin
          timer++;
          if (timer >= rate) begin
            timer = 0;
            fifo.push_back(src.pop_front());
          end
        end
      end
      sd.rd_use = 16'(fifo.size());
    end
  end
  // reference model: expected outputs for the next cycle from this cycle's inputs
  int cyc = 0, n_rd = 0, n_load = 0;
  logic [24:0] last_addr = '0;
  logic m_busy, m_fetching, m_prev_rd, m_err;
  int m_load_cyc, m_done_cyc, m_ready_cyc, m_pops, m_caps, m_idle;
  logic [24:0] m_addr;
  logic [7:0] m_row, m_rn;
  cell_t m_back [COLS];
  cell_t m_front [COLS];
  function automatic void model_reset();
    m_busy = 0; m_fetching = 0; m_prev_rd = 0; m_err = 0;
    m_load_cyc = -1; m_done_cyc = -1; m_ready_cyc = -1;
    m_pops = 0; m_caps = 0; m_idle = 0; m_addr = '0; m_row = '0; m_rn = '0;
    foreach (m_back[i]) begin
      m_back[i] = '0;
      m_front[i] = '0;
    end
  endfunction
  function automatic void advance(input logic er);
    logic was_busy;
    was_busy = m_busy;
    if (m_done_cyc >= 0 && cyc > m_done_cyc && hs) begin
      m_front = m_back;
      m_rn = m_row;
      m_ready_cyc = cyc + 1;
      m_done_cyc = -1;
      m_busy = 0;
    end
    if (m_fetching) begin
      if (m_prev_rd) begin
        m_back[m_caps] = sd.rd_data;
        m_caps++;
        m_idle = 0;
        if (m_caps == COLS) begin
          m_fetching = 0;
          m_done_cyc = cyc + 1;
        end
      end else begin
        m_idle++;
        if (m_idle == TMO) begin
          m_fetching = 0;
          m_err = 1;
          m_done_cyc = cyc + 1;
        end
      end
    end
    m_prev_rd = er;
    m_pops += int'(er);
    if (cyc == m_load_cyc) begin
      m_fetching = 1;
      m_pops = 0; m_caps = 0; m_idle = 0; m_prev_rd = 0;
    end
    if (!was_busy && ld_row && cyc != m_ready_cyc) begin
      m_row = row_num;
      m_busy = 1;
      foreach (m_back[i]) m_back[i] = '0;
      if (int'(row_num) < ROWS) begin
        m_load_cyc = cyc + 1;
        m_addr = 25'(int'(row_num) * STRIDE);
      end else m_done_cyc = cyc + 1;
    end
  endfunction
  initial begin : compare
    logic er;
    forever begin
      @(negedge Clk);
      cyc++;
      if (Reset) model_reset();
      er = m_fetching && m_pops < COLS && (sd.rd_use > 16'd1 || (sd.rd_use == 16'd1 && !m_prev_rd));
      chk("busy", busy, m_busy);
      chk("rd_load", sd.rd_load, cyc == m_load_cyc);
      if (Reset) chk("rd_addr_reset", sd.rd_addr, 0);
      if (sd.rd_load) chk("rd_addr", sd.rd_addr, m_addr);
      chk("rd", sd.rd, er);
      chk("row_ready", row_ready, cyc == m_ready_cyc);
      chk("row_num_out", row_num_out, m_rn);
      chk("fetch_err", fetch_err, m_err);
      for (int i = 0; i < COLS; i++) chk("row_data", row_data[i], m_front[i]);
      n_rd += int'(sd.rd);
      n_load += int'(sd.rd_load);
      if (sd.rd_load) last_addr = sd.rd_addr;
      if (!Reset) advance(er);
    end
  end
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge Clk);
      #2;
    end
  endtask
  task automatic fetch(input logic [7:0] r);
    ld_row = 1'b1;
    row_num = r;
    step();
    ld_row = 1'b0;
  endtask
  task automatic load_src(input cell_t base, input int n, input int rt);
    src.delete();
    for (int i = 0; i < n; i++) src.push_back(base + cell_t'(i));
    rate = rt;
  endtask
  task automatic swap_now();
    hs = 1'b1;
    step();
    hs = 1'b0;
    step();
  endtask
  initial begin : stim
    int l0, r0, k;
    step(3);
    chk("reset_busy", busy, 0);
    chk("reset_row_num_out", row_num_out, 0);
    chk("reset_fetch_err", fetch_err, 0);
    chk("reset_rd_addr", sd.rd_addr, 0);
    chk("reset_cell0", row_data[0], 0);
    Reset = 1'b0;
    step(2);
    // basic fetch of row 3
    load_src(16'h0A00, 10, 0);
    l0 = n_load;
    r0 = n_rd;
    fetch(8'd3);
    step(20);
    swap_now();
    chk("basic_loads", n_load - l0, 1);
    chk("basic_addr", last_addr, 48);
    chk("basic_pops", n_rd - r0, 10);
    chk("basic_cell0", row_data[0], 16'h0A00);
    chk("basic_cell9", row_data[9], 16'h0A09);
    chk("basic_row", row_num_out, 3);
    // slow FIFO, one word every 5 cycles
    load_src(16'h0B00, 10, 5);
    r0 = n_rd;
    fetch(8'd7);
    step(70);
    swap_now();
    chk("slow_pops", n_rd - r0, 10);
    chk("slow_cell9", row_data[9], 16'h0B09);
    chk("slow_err", fetch_err, 0);
    chk("slow_row", row_num_out, 7);
    // out-of-range row
    l0 = n_load;
    r0 = n_rd;
    fetch(8'd25);
    step(5);
    swap_now();
    chk("oor_loads", n_load - l0, 0);
    chk("oor_pops", n_rd - r0, 0);
    chk("oor_cell0", row_data[0], 0);
    chk("oor_row", row_num_out, 25);
    // ignored ld_row during fill, hs in the DONE-entry cycle
    load_src(16'h0C00, 12, 0);
    r0 = n_rd;
    fetch(8'd5);
    step(3);
    ld_row = 1'b1;
    row_num = 8'd7;
    step(3);
    ld_row = 1'b0;
    step(6);
    hs = 1'b1;
    step();
    hs = 1'b0;
    step(2);
    chk("hs_entry_busy", busy, 1);
    chk("hs_entry_row", row_num_out, 25);
    step();
    hs = 1'b1;
    step();
    hs = 1'b0;
    @(negedge Clk);
    chk("hs_next_ready", row_ready, 1);
    chk("hs_next_row", row_num_out, 5);
    step();
    chk("busy_pops", n_rd - r0, 10);
    // timeout after 4 words
    load_src(16'h0D00, 4, 0);
    fetch(8'd2);
    k = 0;
    while (!fetch_err && k < 400) begin
      step();
      k++;
    end
    chk("tmo_cycles", k, 262);
    step(3);
    swap_now();
    chk("tmo_cell3", row_data[3], 16'h0D03);
    chk("tmo_cell4", row_data[4], 0);
    chk("tmo_row", row_num_out, 2);
    load_src(16'h0E00, 12, 0);
    fetch(8'd4);
    step(20);
    swap_now();
    chk("tmo_sticky", fetch_err, 1);
    chk("after_tmo_cell0", row_data[0], 16'h0E00);
    // reset after 5 pops
    load_src(16'h0F00, 12, 0);
    r0 = n_rd;
    fetch(8'd6);
    k = 0;
    while (n_rd - r0 < 5 && k < 50) begin
      step();
      k++;
    end
    chk("mid_pops", n_rd - r0, 5);
    #1;
    Reset = 1'b1;
    #1;
    chk("mid_busy", busy, 0);
    chk("mid_rd", sd.rd, 0);
    chk("mid_err", fetch_err, 0);
    chk("mid_cell0", row_data[0], 0);
    chk("mid_row", row_num_out, 0);
    step(2);
    Reset = 1'b0;
    step(2);
    load_src(16'h0100, 12, 0);
    fetch(8'd1);
    step(20);
    swap_now();
    chk("post_cell0", row_data[0], 16'h0100);
    chk("post_cell9", row_data[9], 16'h0109);
    chk("post_row", row_num_out, 1);
    step(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
